board_keys: RTL and testbench

Input-side counterpart of the board LED/7-segment display: it reads the DE2 push-buttons and slide switches and turns them into NES CPU debug controls. Every key and switch is synchronized and debounced. Key presses become single-cycle pulses that drive a run/pause/single-step state machine, and switches provide a PC breakpoint address. Outputs go to the NES CPU core: halt and reset request. Breakpoint and state indications go to the LED logic.

---
 rtl/board_keys_pkg.sv | 40 ++++
 rtl/board_keys_debounce_bit.sv | 78 +++++++
 rtl/board_keys.sv | 166 ++++++++++++++++
 tb/tb_board_keys.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_keys_pkg.sv
// -----------------------------------------------------------------------------
// board_keys_pkg
//   Shared definitions for the DE2 debug-key front end:
//     - debug FSM state encoding (also the o_dbg_state encoding)
//     - push-button indices inside the 4-bit KEY bus
//     - slide-switch bit positions inside the 18-bit SW bus
//     - small decode helper for the CPU halt request
// -----------------------------------------------------------------------------
package board_keys_pkg;

  localparam int N_KEYS = 4;
  localparam int N_SW   = 18;

  // Debug FSM states. The numeric values are visible on o_dbg_state and are
  // relied on by the LED logic, so they must not be re-ordered.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_STEP  = 2'd2,
    ST_RESET = 2'd3
  } dbg_state_t;

  // Push-button roles (index into i_KEY).
  localparam int KEY_RST  = 0;  // CPU reset
  localparam int KEY_RUN  = 1;  // run/pause toggle
  localparam int KEY_STEP = 2;  // single step
  localparam int KEY_CLR  = 3;  // clear breakpoint indication

  // Slide-switch roles (index into i_SW / o_sw).
  localparam int SW_BP_ADDR_LSB  = 0;   // SW[15:0] breakpoint address
  localparam int SW_BP_ADDR_W    = 16;
  localparam int SW_START_PAUSED = 16;  // leave RESET into PAUSE instead of RUN
  localparam int SW_BP_EN        = 17;  // breakpoint compare enable

  // The CPU is stalled while paused and while being held in reset.
  function automatic logic state_halts(input dbg_state_t s);
    return (s == ST_PAUSE) || (s == ST_RESET);
  endfunction

endpackage

// File: rtl/board_keys_debounce_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
//   Conditions one raw, asynchronous board input:
//     2-FF synchronizer -> debounce counter -> stable level -> fall-edge pulse.
//
//   A new level is accepted on the P_DEBOUNCE-th consecutive synchronized
//   sample that differs from the current stable level; any matching sample
//   restarts the count. The counter is cleared when it reaches its last
//   value, so it never wraps.
//
//   Latency: a change present before edge N is sampled by the first
//   synchronizer flop at N, reaches the counter input at N+1, and updates
//   o_level at edge N+1+P_DEBOUNCE. o_fall is registered one edge later.
//
// Parameters
//   P_DEBOUNCE : consecutive differing samples needed (>= 2)
//   P_INIT     : reset value of the synchronizer and stable level
// Ports
//   i_clk   : system clock
//   i_rstn  : asynchronous active-low reset
//   i_raw   : raw, asynchronous input
//   o_level : debounced stable level
//   o_fall  : one-cycle pulse, the cycle after o_level goes 1 -> 0
// -----------------------------------------------------------------------------
module debounce_bit #(
  parameter int   P_DEBOUNCE = 500000,
  parameter logic P_INIT     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_raw,
  output logic o_level,
  output logic o_fall
);

  localparam int              CW       = $clog2(P_DEBOUNCE);
  localparam logic [CW-1:0]   CNT_LAST = CW'(P_DEBOUNCE - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          level_q;
  logic          level_d1_q;
  logic          fall_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync_q1    <= P_INIT;
      sync_q2    <= P_INIT;
      level_q    <= P_INIT;
      level_d1_q <= P_INIT;
      fall_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync_q1 <= i_raw;
      sync_q2 <= sync_q1;

      if (sync_q2 == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        // This sample is the P_DEBOUNCE-th differing one in a row.
        cnt_q   <= '0;
        level_q <= sync_q2;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end

      // Delayed copy of the stable level: the fall pulse is registered from
      // two registered values, so it is high the cycle after the level drops.
      level_d1_q <= level_q;
      fall_q     <= level_d1_q & ~level_q;
    end
  end

  assign o_level = level_q;
  assign o_fall  = fall_q;

endmodule

// File: rtl/board_keys.sv
// -----------------------------------------------------------------------------
// board_keys
//   DE2 push-buttons / slide switches -> NES CPU debug controls.
//
//   Every key and switch is synchronized and debounced (debounce_bit). Key
//   presses become single-cycle pulses that drive a run/pause/single-step
//   FSM; switches supply a PC breakpoint address, breakpoint enable and the
//   "start paused" option used when leaving the CPU reset pulse.
//
//   Event semantics: a key pulse or an i_nes_cpu_sync strobe is an event for
//   exactly the cycle it is high; there is no back-pressure. An event seen in
//   cycle k is reflected on the outputs in cycle k+1.
//
//   Same-cycle priority: KEY0 > breakpoint > KEY1 > KEY2. In STEP the opcode
//   fetch that completes the step is taken ahead of KEY1.
//
// Parameters
//   P_DEBOUNCE   : debounce length in clock cycles (>= 2)
//   P_RST_CYCLES : length of the CPU reset pulse in clock cycles (>= 1)
// Ports
//   i_clk          : system clock
//   i_rstn         : asynchronous active-low reset
//   i_KEY[3:0]     : raw push-buttons, active-low
//   i_SW[17:0]     : raw slide switches
//   i_nes_cpu_pc   : current CPU program counter
//   i_nes_cpu_sync : one-cycle opcode fetch strobe
//   o_cpu_halt     : 1 = CPU must stall (PAUSE, RESET)
//   o_cpu_rstn     : active-low CPU reset request (low in RESET)
//   o_bp_hit       : sticky breakpoint indication
//   o_dbg_state    : FSM state (RUN=0, PAUSE=1, STEP=2, RESET=3)
//   o_sw           : debounced switch levels
// -----------------------------------------------------------------------------
module board_keys
  import board_keys_pkg::*;
#(
  parameter int P_DEBOUNCE   = 500000,
  parameter int P_RST_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [3:0]  i_KEY,
  input  logic [17:0] i_SW,
  input  logic [15:0] i_nes_cpu_pc,
  input  logic        i_nes_cpu_sync,
  output logic        o_cpu_halt,
  output logic        o_cpu_rstn,
  output logic        o_bp_hit,
  output logic [1:0]  o_dbg_state,
  output logic [17:0] o_sw
);

  localparam int             RCW      = $clog2(P_RST_CYCLES + 1);
  localparam logic [RCW-1:0] RST_LAST = RCW'(P_RST_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  // Keys idle high (released); switches idle low.
  logic [N_KEYS-1:0] key_level_unused;
  logic [N_KEYS-1:0] key_press;
  logic [N_SW-1:0]   sw_fall_unused;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    debounce_bit #(
      .P_DEBOUNCE (P_DEBOUNCE),
      .P_INIT     (1'b1)
    ) u_db (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_raw   (i_KEY[g]),
      .o_level (key_level_unused[g]),
      .o_fall  (key_press[g])
    );
  end

  for (genvar g = 0; g < N_SW; g++) begin : g_sw
    debounce_bit #(
      .P_DEBOUNCE (P_DEBOUNCE),
      .P_INIT     (1'b0)
    ) u_db (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_raw   (i_SW[g]),
      .o_level (o_sw[g]),
      .o_fall  (sw_fall_unused[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Breakpoint comparator (only acted on in RUN)
  // ---------------------------------------------------------------------------
  logic [SW_BP_ADDR_W-1:0] bp_addr;
  logic                    bp_match;

  assign bp_addr  = o_sw[SW_BP_ADDR_LSB +: SW_BP_ADDR_W];
  assign bp_match = i_nes_cpu_sync && o_sw[SW_BP_EN] && (i_nes_cpu_pc == bp_addr);

  // ---------------------------------------------------------------------------
  // Debug FSM, reset-pulse counter and sticky breakpoint flag
  // ---------------------------------------------------------------------------
  dbg_state_t     state_q;
  logic [RCW-1:0] rst_cnt_q;
  logic           bp_hit_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= ST_RUN;
      rst_cnt_q <= '0;
      bp_hit_q  <= 1'b0;
    end else if (key_press[KEY_RST]) begin
      // Reset key wins in every state and restarts the reset pulse, even
      // when already in RESET.
      state_q   <= ST_RESET;
      rst_cnt_q <= '0;
      bp_hit_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bp_match || key_press[KEY_RUN]) begin
            state_q <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (key_press[KEY_RUN]) begin
            state_q <= ST_RUN;
          end else if (key_press[KEY_STEP]) begin
            state_q <= ST_STEP;
          end
        end
        ST_STEP: begin
          // One opcode fetch completes the step; breakpoints are ignored.
          if (i_nes_cpu_sync) begin
            state_q <= ST_PAUSE;
          end else if (key_press[KEY_RUN]) begin
            state_q <= ST_RUN;
          end
        end
        ST_RESET: begin
          // RESET is held for exactly P_RST_CYCLES cycles: counts 0..LAST.
          if (rst_cnt_q == RST_LAST) begin
            state_q <= o_sw[SW_START_PAUSED] ? ST_PAUSE : ST_RUN;
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase

      // A breakpoint set takes precedence over a same-cycle clear key.
      if ((state_q == ST_RUN) && bp_match) begin
        bp_hit_q <= 1'b1;
      end else if (key_press[KEY_CLR]) begin
        bp_hit_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all decoded from registered state
  // ---------------------------------------------------------------------------
  assign o_dbg_state = state_q;
  assign o_cpu_halt  = state_halts(state_q);
  assign o_cpu_rstn  = (state_q != ST_RESET);
  assign o_bp_hit    = bp_hit_q;

endmodule

// File: tb/tb_board_keys.sv
// -----------------------------------------------------------------------------
// tb_board_keys
//   Directed scenarios plus a randomized phase. A behavioural model (input
//   delay line, per-input run lengths, state numbers from the state table)
//   produces the expected outputs after every clock edge into exp_q; each
//   cycle the DUT outputs are compared against the front of that queue.
//   Directed constants cover reset values, debounce latency, reset-pulse
//   length and the same-cycle priority cases.
// -----------------------------------------------------------------------------
module tb_board_keys;

  localparam int P_DEB = 8;
  localparam int P_RST = 16;
  localparam int W     = 23;  // {state[1:0], halt, rstn, bp_hit, sw[17:0]}

  localparam int S_RUN   = 0;
  localparam int S_PAUSE = 1;
  localparam int S_STEP  = 2;
  localparam int S_RESET = 3;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  key;
  logic [17:0] sw;
  logic [15:0] pc;
  logic        sync;

  logic        o_cpu_halt;
  logic        o_cpu_rstn;
  logic        o_bp_hit;
  logic [1:0]  o_dbg_state;
  logic [17:0] o_sw;

  always #5 clk = ~clk;

  board_keys #(
    .P_DEBOUNCE   (P_DEB),
    .P_RST_CYCLES (P_RST)
  ) dut (
    .i_clk          (clk),
    .i_rstn         (rst_n),
    .i_KEY          (key),
    .i_SW           (sw),
    .i_nes_cpu_pc   (pc),
    .i_nes_cpu_sync (sync),
    .o_cpu_halt     (o_cpu_halt),
    .o_cpu_rstn     (o_cpu_rstn),
    .o_bp_hit       (o_bp_hit),
    .o_dbg_state    (o_dbg_state),
    .o_sw           (o_sw)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int            checks   = 0;
  int            failures = 0;
  logic [W-1:0]  exp_q[$];
  int            low_run  = 0;
  int            last_low = 0;

  // Reference model: bits [3:0] = keys, [21:4] = switches.
  logic [21:0]   m_lvl;
  logic [21:0]   m_lvl_d1;
  logic [21:0]   m_dq[$];
  int            m_run[22];
  logic [3:0]    m_fall;
  int            m_state;
  int            m_rst_left;
  logic          m_bp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lvl      = 22'h00000F;
    m_lvl_d1   = 22'h00000F;
    m_dq       = '{22'h00000F, 22'h00000F};
    foreach (m_run[b]) m_run[b] = 0;
    m_fall     = 4'h0;
    m_state    = S_RUN;
    m_rst_left = 0;
    m_bp       = 1'b0;
    exp_q.delete();
  endtask

  // One rising clock edge of the model, using the inputs held before it.
  task automatic model_edge();
    logic [21:0] samp;
    logic [17:0] s;
    logic [3:0]  p;
    logic        hit;
    int          st0;
    s   = m_lvl[21:4];
    p   = m_fall;
    st0 = m_state;
    hit = sync && s[17] && (pc == s[15:0]);

    if (p[0]) begin
      m_state    = S_RESET;
      m_rst_left = P_RST;
      m_bp       = 1'b0;
    end else begin
      if (st0 == S_RUN) begin
        if (hit || p[1]) m_state = S_PAUSE;
      end else if (st0 == S_PAUSE) begin
        if (p[1]) m_state = S_RUN;
        else if (p[2]) m_state = S_STEP;
      end else if (st0 == S_STEP) begin
        if (sync) m_state = S_PAUSE;
        else if (p[1]) m_state = S_RUN;
      end else begin
        m_rst_left--;
        if (m_rst_left == 0) m_state = s[16] ? S_PAUSE : S_RUN;
      end
      if (st0 == S_RUN && hit) m_bp = 1'b1;
      else if (p[3]) m_bp = 1'b0;
    end

    // Press pulse: stable level was 1 two edges ago and 0 one edge ago.
    m_fall   = m_lvl_d1[3:0] & ~m_lvl[3:0];
    m_lvl_d1 = m_lvl;

    // Two-edge input delay, then P_DEB consecutive differing samples flip.
    samp = m_dq.pop_front();
    m_dq.push_back({sw, key});
    for (int b = 0; b < 22; b++) begin
      if (samp[b] != m_lvl[b]) begin
        m_run[b]++;
        if (m_run[b] == P_DEB) begin
          m_lvl[b] = samp[b];
          m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
    end

    exp_q.push_back({2'(m_state),
                     (m_state == S_PAUSE) || (m_state == S_RESET),
                     (m_state != S_RESET),
                     m_bp,
                     m_lvl[21:4]});
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    logic [W-1:0] e;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    e = exp_q.pop_front();
    check("state_flags", {27'd0, o_dbg_state, o_cpu_halt, o_cpu_rstn, o_bp_hit}, {27'd0, e[22:18]});
    check("o_sw", {14'd0, o_sw}, {14'd0, e[17:0]});
    if (!o_cpu_rstn) begin
      low_run++;
    end else begin
      if (low_run != 0) last_low = low_run;
      low_run = 0;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) step();
  endtask

  task automatic press(input int k);
    key[k] = 1'b0;
    cyc(P_DEB + 4);
    key[k] = 1'b1;
    cyc(P_DEB + 6);
  endtask

  task automatic cpu_sync(input logic [15:0] addr);
    pc   = addr;
    sync = 1'b1;
    step();
    sync = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, o_dbg_state, 0);
    check({tag, "_halt"},  o_cpu_halt,  0);
    check({tag, "_rstn"},  o_cpu_rstn,  1);
    check({tag, "_bp"},    o_bp_hit,    0);
    check({tag, "_sw"},    o_sw,        0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int rise;
    int found;
    int kind;
    int len;

    // Reset
    rst_n = 1'b0;
    key   = 4'hF;
    sw    = '0;
    pc    = '0;
    sync  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    cyc(5);

    // Debounce: SW3 bounces in 5-cycle segments, then holds high.
    sw[3] = 1'b1; cyc(5);
    sw[3] = 1'b0; cyc(5);
    sw[3] = 1'b1; cyc(5);
    sw[3] = 1'b0; cyc(5);
    check("sw3_no_early", o_sw[3], 0);
    sw[3] = 1'b1;
    rise = -1;
    // Step e=1 is edge N, the first edge that samples the final change.
    for (int e = 1; e <= 20; e++) begin
      step();
      if (o_sw[3] && rise < 0) rise = e;
    end
    check("sw3_rise_edges_after_N", rise - 1, P_DEB + 1);

    // CPU reset pulse, leaving into PAUSE.
    sw[16] = 1'b1;
    cyc(P_DEB + 4);
    last_low = 0;
    press(0);
    cyc(P_RST + 4);
    check("rst_low_cycles", last_low, P_RST);
    check("rst_exit_state", o_dbg_state, S_PAUSE);
    check("rst_exit_halt", o_cpu_halt, 1);

    // Run / pause / step
    press(1);
    check("run_state", o_dbg_state, S_RUN);
    check("run_halt", o_cpu_halt, 0);
    press(1);
    check("pause_state", o_dbg_state, S_PAUSE);
    check("pause_halt", o_cpu_halt, 1);
    press(2);
    check("step_state", o_dbg_state, S_STEP);
    check("step_halt", o_cpu_halt, 0);
    cpu_sync(16'($urandom));
    check("step_done_state", o_dbg_state, S_PAUSE);
    check("step_done_halt", o_cpu_halt, 1);

    // Breakpoint at C000, start-paused off.
    sw = {1'b1, 1'b0, 16'hC000};
    cyc(P_DEB + 4);
    press(1);
    check("bp_run_state", o_dbg_state, S_RUN);
    cpu_sync(16'hBFFF);
    check("bp_miss_state", o_dbg_state, S_RUN);
    check("bp_miss_flag", o_bp_hit, 0);
    cpu_sync(16'hC000);
    check("bp_hit_state", o_dbg_state, S_PAUSE);
    check("bp_hit_flag", o_bp_hit, 1);
    check("bp_hit_halt", o_cpu_halt, 1);
    press(3);
    check("bp_clear_flag", o_bp_hit, 0);

    // Breakpoint and KEY1 pulse in the same cycle: one transition only.
    press(1);
    check("prio_pre_state", o_dbg_state, S_RUN);
    key[1] = 1'b0;
    cyc(P_DEB + 3);
    check("prio_pulse_aligned", m_fall[1], 1);
    cpu_sync(16'hC000);
    cyc(4);
    key[1] = 1'b1;
    cyc(P_DEB + 6);
    check("prio_bp_vs_key1_state", o_dbg_state, S_PAUSE);
    check("prio_bp_vs_key1_flag", o_bp_hit, 1);

    // KEY0 during STEP: RESET wins and clears the breakpoint flag.
    press(2);
    check("prio_step_state", o_dbg_state, S_STEP);
    key[0] = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      step();
      if (!o_cpu_rstn) found = 1;
    end
    check("key0_step_seen", found, 1);
    check("key0_step_state", o_dbg_state, S_RESET);
    check("key0_step_bp", o_bp_hit, 0);
    key[0] = 1'b1;
    cyc(P_DEB + P_RST + 8);
    check("key0_step_exit", o_dbg_state, S_RUN);

    // Randomized phase: key presses and short glitches, switch changes,
    // random opcode fetches.
    for (int seg = 0; seg < 50; seg++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, P_DEB + 6);
      if (kind == 0) begin
        sw = {2'($urandom_range(0, 3)), ($urandom_range(0, 1) != 0) ? 16'hC000 : 16'($urandom)};
      end else if (kind < 9) begin
        key[$urandom_range(1, 3)] = 1'b0;
      end else begin
        key[0] = 1'b0;
      end
      for (int i = 0; i < len; i++) begin
        sync = ($urandom_range(0, 2) == 0);
        case ($urandom_range(0, 2))
          0:       pc = 16'hC000;
          1:       pc = 16'hBFFF;
          default: pc = 16'($urandom);
        endcase
        step();
      end
      key  = 4'hF;
      sync = 1'b0;
      cyc($urandom_range(1, P_DEB + 6));
    end
    cyc(P_DEB + P_RST + 8);

    // Async reset in the middle of a debounce.
    sw = 18'h3C000;
    cyc(P_DEB + 4);
    sw = 18'h00005;
    cyc(4);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_debounce");
    model_reset();
    key = 4'hF;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(P_DEB + 4);

    // Async reset in the middle of the CPU reset pulse.
    key[0] = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      step();
      if (!o_cpu_rstn) found = 1;
    end
    check("async_rst_seen", found, 1);
    cyc(3);
    #2 rst_n = 1'b0;
    #1 check("async_pulse_rstn", o_cpu_rstn, 1);
    check("async_pulse_state", o_dbg_state, S_RUN);
    check("async_pulse_halt", o_cpu_halt, 0);
    model_reset();
    key = 4'hF;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(P_DEB + 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the run must always end on its own.
  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
